// File: rtl/pixel_pkg.sv
// Shared opcode values and FSM state encoding for the pixel stream processor.
package pixel_pkg;

  localparam logic [2:0] OP_BRIGHT = 3'd0;
  localparam logic [2:0] OP_GRAY   = 3'd1;
  localparam logic [2:0] OP_INVERT = 3'd2;
  localparam logic [2:0] OP_THRESH = 3'd3;
  localparam logic [2:0] OP_BYPASS = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/pixel_op_alu.sv
// Combinational per-pixel datapath. The first half produces the sums that the
// parent registers into S1; the second half turns those into the S2 result.
module pixel_op_alu
  import pixel_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic [2:0][PIX_W-1:0] pix,
  input  logic [PIX_W:0]        bright,
  output logic [2:0][PIX_W+1:0] bright_sum,
  output logic [PIX_W+1:0]      gray_sum,
  input  logic [2:0]            opcode,
  input  logic [PIX_W-1:0]      thresh,
  input  logic [2:0][PIX_W-1:0] s1_pix,
  input  logic [2:0][PIX_W+1:0] s1_bright_sum,
  input  logic [PIX_W+1:0]      s1_gray_sum,
  output logic [2:0][PIX_W-1:0] result
);

  localparam logic [PIX_W-1:0] PIX_MAX = '1;

  logic [PIX_W-1:0] gray;
  logic             gray_hit;

  assign gray_sum = {2'b00, pix[2]} + {1'b0, pix[1], 1'b0} + {2'b00, pix[0]};
  assign gray     = s1_gray_sum[PIX_W+1:2];
  assign gray_hit = (gray >= thresh);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic [PIX_W-1:0] sat;
      logic [PIX_W-1:0] res;

      // Two's-complement sum in PIX_W+2 bits: MSB set means negative,
      // next bit set means the sum overflowed the channel range.
      assign bright_sum[gi] = {2'b00, pix[gi]} + {bright[PIX_W], bright};
      assign sat = s1_bright_sum[gi][PIX_W+1] ? '0 :
                   s1_bright_sum[gi][PIX_W]   ? PIX_MAX :
                                                s1_bright_sum[gi][PIX_W-1:0];

      always_comb begin
        res = s1_pix[gi];
        case (opcode)
          OP_BRIGHT: res = sat;
          OP_GRAY:   res = gray;
          OP_INVERT: res = PIX_MAX - s1_pix[gi];
          OP_THRESH: res = gray_hit ? PIX_MAX : '0;
          default:   res = s1_pix[gi];
        endcase
      end

      assign result[gi] = res;
    end
  endgenerate

endmodule

// File: rtl/pixel_stream_proc.sv
// Streaming RGB pixel processor: frame FSM, raster counters and a 2-stage
// pipeline that stalls as a whole whenever the output is held.
module pixel_stream_proc
  import pixel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int DIM_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [PIX_W:0]   bright,
  input  logic [PIX_W-1:0] thresh,
  input  logic [DIM_W-1:0] width,
  input  logic [DIM_W-1:0] height,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_red,
  input  logic [PIX_W-1:0] in_green,
  input  logic [PIX_W-1:0] in_blue,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_red,
  output logic [PIX_W-1:0] out_green,
  output logic [PIX_W-1:0] out_blue,
  output logic [DIM_W-1:0] out_row,
  output logic [DIM_W-1:0] out_col,
  output logic             out_last,
  output logic             done
);

  state_t                 state_reg;
  logic [2:0]             op_reg;
  logic [PIX_W:0]         bright_reg;
  logic [PIX_W-1:0]       thresh_reg;
  logic [DIM_W-1:0]       row_max_reg, col_max_reg;
  logic [2*DIM_W-1:0]     total_reg, acc_reg;
  logic [DIM_W-1:0]       row_reg, col_reg;
  logic                   done_reg;

  logic                   s1_valid_reg, out_valid_reg;
  logic [2:0][PIX_W-1:0]  s1_pix_reg, out_pix_reg;
  logic [2:0][PIX_W+1:0]  s1_bright_sum_reg;
  logic [PIX_W+1:0]       s1_gray_sum_reg;

  logic [2:0][PIX_W-1:0]  in_pix, alu_result;
  logic [2:0][PIX_W+1:0]  bright_sum;
  logic [PIX_W+1:0]       gray_sum;
  logic                   en, in_hs, out_hs;

  assign en       = !out_valid_reg || out_ready;
  assign in_ready = (state_reg == ST_RUN) && (acc_reg < total_reg) && en;
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid_reg && out_ready;
  assign out_last = out_valid_reg && (row_reg == row_max_reg) && (col_reg == col_max_reg);
  assign in_pix   = {in_red, in_green, in_blue};

  pixel_op_alu #(.PIX_W(PIX_W)) u_alu (
    .pix           (in_pix),
    .bright        (bright_reg),
    .bright_sum    (bright_sum),
    .gray_sum      (gray_sum),
    .opcode        (op_reg),
    .thresh        (thresh_reg),
    .s1_pix        (s1_pix_reg),
    .s1_bright_sum (s1_bright_sum_reg),
    .s1_gray_sum   (s1_gray_sum_reg),
    .result        (alu_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      op_reg      <= '0;
      bright_reg  <= '0;
      thresh_reg  <= '0;
      row_max_reg <= '0;
      col_max_reg <= '0;
      total_reg   <= '0;
      acc_reg     <= '0;
      row_reg     <= '0;
      col_reg     <= '0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (out_hs) begin
        if (col_reg == col_max_reg) begin
          col_reg <= '0;
          row_reg <= row_reg + 1'b1;
        end else begin
          col_reg <= col_reg + 1'b1;
        end
      end
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            op_reg      <= opcode;
            bright_reg  <= bright;
            thresh_reg  <= thresh;
            row_max_reg <= height - 1'b1;
            col_max_reg <= width - 1'b1;
            total_reg   <= {{DIM_W{1'b0}}, width} * {{DIM_W{1'b0}}, height};
            acc_reg     <= '0;
            row_reg     <= '0;
            col_reg     <= '0;
            if (width == '0 || height == '0) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (in_hs) begin
            acc_reg <= acc_reg + 1'b1;
            if (acc_reg + 1'b1 == total_reg) state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (out_hs && out_last) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg      <= 1'b0;
      s1_pix_reg        <= '0;
      s1_bright_sum_reg <= '0;
      s1_gray_sum_reg   <= '0;
      out_valid_reg     <= 1'b0;
      out_pix_reg       <= '0;
    end else if (en) begin
      s1_valid_reg      <= in_hs;
      s1_pix_reg        <= in_pix;
      s1_bright_sum_reg <= bright_sum;
      s1_gray_sum_reg   <= gray_sum;
      out_valid_reg     <= s1_valid_reg;
      out_pix_reg       <= alu_result;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_red   = out_pix_reg[2];
  assign out_green = out_pix_reg[1];
  assign out_blue  = out_pix_reg[0];
  assign out_row   = row_reg;
  assign out_col   = col_reg;
  assign done      = done_reg;

endmodule
